// File: rtl/ng_tpg.sv
// ng_tpg: time pulse generator for the ng_AGC core.
// Produces the 4-bit TPG code (Standby, PowerOn, TP1..TP12, SRLSE, WAIT)
// that drives the CPM decoder, and counts completed memory cycles.
// Panel inputs (RUN, STEP, INST, STBY) are asynchronous and pass through a
// SYNC_STAGES-deep synchronizer; STRT and SNI are already synchronous.
// SYNC_STAGES must be 2 or 3.
module ng_tpg #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK2,
  input  logic       NPURST,
  input  logic       STRT,
  input  logic       SNI,
  input  logic       RUN,
  input  logic       STEP,
  input  logic       INST,
  input  logic       STBY,
  output logic [3:0] TPG,
  output logic       STOPPED,
  output logic [7:0] MCT_CNT
);

  // Encoding is fixed: the CPM decoder depends on these exact values.
  typedef enum logic [3:0] {
    ST_STANDBY = 4'd0,
    ST_POWERON = 4'd1,
    ST_TP1     = 4'd2,
    ST_TP2     = 4'd3,
    ST_TP3     = 4'd4,
    ST_TP4     = 4'd5,
    ST_TP5     = 4'd6,
    ST_TP6     = 4'd7,
    ST_TP7     = 4'd8,
    ST_TP8     = 4'd9,
    ST_TP9     = 4'd10,
    ST_TP10    = 4'd11,
    ST_TP11    = 4'd12,
    ST_TP12    = 4'd13,
    ST_SRLSE   = 4'd14,
    ST_WAIT    = 4'd15
  } state_t;

  state_t state_q;
  state_t state_d;

  // Each stage holds {stby, inst, step, run}; stage SYNC_STAGES-1 is the
  // synchronized output.
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic                        run_s;
  logic                        step_s;
  logic                        inst_s;
  logic                        stby_s;
  logic [7:0]                  mct_q;

  // Panel synchronizer chain: shift the raw panel levels in every edge.
  // NOTE: the synchronizer flops are reset too, so a stale panel level cannot
  // leak through in the first edges after power-up reset.
  always_ff @(posedge CLK2 or negedge NPURST) begin
    if (!NPURST) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so stage order in the code does not matter.
      sync_q <= {sync_q[SYNC_STAGES-2:0], {STBY, INST, STEP, RUN}};
    end
  end

  assign {stby_s, inst_s, step_s, run_s} = sync_q[SYNC_STAGES-1];

  // State register.
  always_ff @(posedge CLK2 or negedge NPURST) begin
    if (!NPURST) begin
      state_q <= ST_STANDBY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: power-on, TP sequencing and the panel stops.
  always_comb begin
    // NOTE: defaulting state_d first means every path assigns it, so no
    // latch can be inferred when a branch below leaves it untouched.
    state_d = state_q;
    case (state_q)
      ST_STANDBY: begin
        if (STRT && !stby_s) state_d = ST_POWERON;
      end
      ST_POWERON: state_d = ST_TP1;
      ST_TP12: begin
        if (stby_s)              state_d = ST_STANDBY;
        else if (run_s)          state_d = ST_TP1;
        // Mid-instruction: keep going, stops happen only at instruction ends.
        else if (inst_s && !SNI) state_d = ST_TP1;
        else                     state_d = ST_SRLSE;
      end
      ST_SRLSE: begin
        if (stby_s)      state_d = ST_STANDBY;
        else if (run_s)  state_d = ST_TP1;
        else if (!step_s) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (stby_s)               state_d = ST_STANDBY;
        else if (run_s || step_s) state_d = ST_TP1;
      end
      // TP1..TP11 advance unconditionally; STBY never truncates a cycle.
      default: state_d = state_t'(state_q + 4'd1);
    endcase
  end

  // Memory cycle counter: counts every edge spent in TP12, wraps at 255.
  always_ff @(posedge CLK2 or negedge NPURST) begin
    if (!NPURST) begin
      mct_q <= 8'd0;
    end else if (state_q == ST_TP12) begin
      mct_q <= mct_q + 8'd1;
    end
  end

  assign TPG     = state_q;
  assign STOPPED = (state_q == ST_STANDBY) || (state_q == ST_SRLSE) ||
                   (state_q == ST_WAIT);
  assign MCT_CNT = mct_q;

endmodule

// File: tb/tb_ng_tpg.sv
// Testbench for ng_tpg: expected TPG codes are queued as stimulus is driven
// and compared one per clock; STOPPED and MCT_CNT follow from the expected
// state stream.
module tb_ng_tpg;

  logic       CLK2;
  logic       NPURST;
  logic       STRT;
  logic       SNI;
  logic       RUN;
  logic       STEP;
  logic       INST;
  logic       STBY;
  logic [3:0] TPG;
  logic       STOPPED;
  logic [7:0] MCT_CNT;

  int         checks;
  int         failures;
  logic [3:0] exp_q[$];
  logic [3:0] cur_exp;
  logic [7:0] exp_mct;

  ng_tpg #(.SYNC_STAGES(2)) dut (
    .CLK2    (CLK2),
    .NPURST  (NPURST),
    .STRT    (STRT),
    .SNI     (SNI),
    .RUN     (RUN),
    .STEP    (STEP),
    .INST    (INST),
    .STBY    (STBY),
    .TPG     (TPG),
    .STOPPED (STOPPED),
    .MCT_CNT (MCT_CNT)
  );

  initial CLK2 = 1'b0;
  always #5 CLK2 = ~CLK2;

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge CLK2);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) exp_q.push_back(4'(v));
  endtask

  // Pop n expected states, one per clock, and compare all outputs.
  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] e;
      logic       es;
      tick();
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s: scoreboard empty", tag);
        return;
      end
      e = exp_q.pop_front();
      if (cur_exp == 4'd13) exp_mct = exp_mct + 8'd1;
      cur_exp = e;
      es = (e == 4'd0) || (e == 4'd14) || (e == 4'd15);
      checks++;
      if (TPG !== e) begin
        failures++;
        $display("FAIL %s tpg: got %0d expected %0d", tag, TPG, e);
      end
      checks++;
      if (STOPPED !== es) begin
        failures++;
        $display("FAIL %s stopped: got %b expected %b (tpg exp %0d)", tag, STOPPED, es, e);
      end
      checks++;
      if (MCT_CNT !== exp_mct) begin
        failures++;
        $display("FAIL %s mct_cnt: got %0d expected %0d", tag, MCT_CNT, exp_mct);
      end
    end
  endtask

  task automatic drain_all(input string tag);
    drain(tag, exp_q.size());
  endtask

  task automatic test_reset();
    NPURST = 1'b0;
    RUN    = 1'b1;
    STBY   = 1'b0;
    tick();
    tick();
    STRT = 1'b1;
    tick();
    STRT = 1'b0;
    checks++;
    if (TPG !== 4'd0) begin
      failures++;
      $display("FAIL reset tpg: got %0d expected 0", TPG);
    end
    checks++;
    if (STOPPED !== 1'b1) begin
      failures++;
      $display("FAIL reset stopped: got %b expected 1", STOPPED);
    end
    checks++;
    if (MCT_CNT !== 8'd0) begin
      failures++;
      $display("FAIL reset mct_cnt: got %0d expected 0", MCT_CNT);
    end
    NPURST  = 1'b1;
    cur_exp = 4'd0;
    exp_mct = 8'd0;
    push_range(0, 0);
    push_range(0, 0);
    drain_all("poweron_idle");
    STRT = 1'b1;
    push_range(1, 1);
    drain_all("poweron_strt");
    STRT = 1'b0;
    for (int c = 0; c < 3; c++) push_range(2, 13);
    push_range(2, 2);
    drain_all("poweron_run");
    checks++;
    if (MCT_CNT !== 8'd3) begin
      failures++;
      $display("FAIL poweron mct_after_36: got %0d expected 3", MCT_CNT);
    end
  endtask

  task automatic test_mct_step();
    RUN  = 1'b0;
    INST = 1'b0;
    STEP = 1'b1;
    push_range(3, 13);
    push_range(14, 14);
    push_range(14, 14);
    push_range(14, 14);
    drain_all("mctstep_to_srlse");
    STEP = 1'b0;
    push_range(14, 14);
    push_range(14, 14);
    push_range(15, 15);
    push_range(15, 15);
    drain_all("mctstep_release");
    STEP = 1'b1;
    push_range(15, 15);
    push_range(15, 15);
    push_range(2, 2);
    drain_all("mctstep_press");
    STEP = 1'b0;
    push_range(3, 13);
    push_range(14, 15);
    push_range(15, 15);
    drain_all("mctstep_one_cycle");
  endtask

  task automatic test_inst_step();
    logic [7:0] snap;
    snap = exp_mct;
    INST = 1'b1;
    STEP = 1'b1;
    push_range(15, 15);
    push_range(15, 15);
    push_range(2, 2);
    drain_all("inststep_press");
    STEP = 1'b0;
    push_range(3, 6);
    drain_all("inststep_a");
    // SNI outside TP12 must be ignored.
    SNI = 1'b1;
    push_range(7, 12);
    drain_all("inststep_sni_ignored");
    SNI = 1'b0;
    push_range(13, 13);
    drain_all("inststep_b");
    push_range(2, 13);
    drain_all("inststep_continue");
    SNI = 1'b1;
    push_range(14, 14);
    drain_all("inststep_stop");
    SNI = 1'b0;
    push_range(15, 15);
    push_range(15, 15);
    drain_all("inststep_wait");
    checks++;
    if (MCT_CNT !== 8'(snap + 8'd2)) begin
      failures++;
      $display("FAIL inststep mct_advance: got %0d expected %0d", MCT_CNT, 8'(snap + 8'd2));
    end
  endtask

  task automatic test_standby();
    RUN  = 1'b1;
    INST = 1'b0;
    push_range(15, 15);
    push_range(15, 15);
    push_range(2, 2);
    drain_all("stby_resume");
    push_range(3, 5);
    drain_all("stby_to_tp4");
    STBY = 1'b1;
    push_range(6, 13);
    push_range(0, 0);
    drain_all("stby_finish_cycle");
    for (int k = 0; k < 3; k++) begin
      STRT = 1'b1;
      push_range(0, 0);
      drain_all("stby_strt_ignored");
      STRT = 1'b0;
      push_range(0, 0);
      drain_all("stby_hold");
    end
    STBY = 1'b0;
    push_range(0, 0);
    push_range(0, 0);
    drain_all("stby_release");
    STRT = 1'b1;
    push_range(1, 1);
    drain_all("stby_exit_poweron");
    STRT = 1'b0;
    push_range(2, 2);
    drain_all("stby_exit_tp1");
  endtask

  task automatic test_wrap();
    int n;
    // STRT while running must be ignored.
    STRT = 1'b1;
    push_range(3, 3);
    drain_all("wrap_strt_ignored");
    STRT = 1'b0;
    push_range(4, 13);
    push_range(2, 2);
    drain_all("wrap_first");
    n = 256 - int'(exp_mct);
    for (int c = 0; c < n; c++) begin
      push_range(3, 13);
      push_range(2, 2);
      drain_all("wrap_run");
    end
    checks++;
    if (MCT_CNT !== 8'd0) begin
      failures++;
      $display("FAIL wrap mct_cnt: got %0d expected 0", MCT_CNT);
    end
  endtask

  task automatic test_mid_reset();
    push_range(3, 8);
    drain_all("midreset_to_tp7");
    #2;
    NPURST = 1'b0;
    #1;
    checks++;
    if (TPG !== 4'd0) begin
      failures++;
      $display("FAIL midreset tpg: got %0d expected 0", TPG);
    end
    checks++;
    if (MCT_CNT !== 8'd0) begin
      failures++;
      $display("FAIL midreset mct_cnt: got %0d expected 0", MCT_CNT);
    end
    checks++;
    if (STOPPED !== 1'b1) begin
      failures++;
      $display("FAIL midreset stopped: got %b expected 1", STOPPED);
    end
    tick();
    NPURST  = 1'b1;
    cur_exp = 4'd0;
    exp_mct = 8'd0;
    exp_q.delete();
    push_range(0, 0);
    push_range(0, 0);
    drain_all("midreset_idle");
    STRT = 1'b1;
    push_range(1, 1);
    drain_all("midreset_strt");
    STRT = 1'b0;
    push_range(2, 4);
    drain_all("midreset_run");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cur_exp  = 4'd0;
    exp_mct  = 8'd0;
    NPURST   = 1'b0;
    STRT     = 1'b0;
    SNI      = 1'b0;
    RUN      = 1'b0;
    STEP     = 1'b0;
    INST     = 1'b0;
    STBY     = 1'b0;
    test_reset();
    test_mct_step();
    test_inst_step();
    test_standby();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ng_tpg.md
# ng_tpg

Time pulse generator for the ng_AGC core: a 4-bit state machine that produces the `TPG[3:0]` time-pulse code consumed by the control pulse matrix, the sequence registers and the memory timing. It sequences power-on, the twelve time pulses of each memory cycle (MCT), and the panel-driven run/step/standby stops. It sits directly upstream of the CPM decoder, which decodes `TPG` for the Standby, PowerOn, TP1, TP5, TP6, TP11 and TP12 gating.

## Interface
Parameters:
- `SYNC_STAGES`, default 2. Synchronizer depth for the panel inputs; legal values are 2 or 3.

Ports:
- `CLK2  in  1`: clock. All state changes on the rising edge.
- `NPURST  in  1`: power-up reset. Asynchronous, active-low.
- `STRT  in  1`: start strobe. Synchronous, one `CLK2` wide, from the scaler; exits standby.
- `SNI  in  1`: select next instruction, from the sequencer. Synchronous; sampled only in TP12.
- `RUN  in  1`: panel run switch. Asynchronous level; 1 = free-running.
- `STEP  in  1`: panel step pushbutton. Asynchronous level; 1 = pressed.
- `INST  in  1`: panel step-mode select. Asynchronous level; 1 = instruction step, 0 = MCT step.
- `STBY  in  1`: panel standby request. Asynchronous level; 1 = enter/remain in standby.
- `TPG  out  4`: time pulse code. Registered.
- `STOPPED  out  1`: 1 when `TPG` is Standby, SRLSE or WAIT. Decoded from the registered state.
- `MCT_CNT  out  8`: count of completed memory cycles. Registered, wraps.

## Operation
- State encoding, which is fixed and shared with the CPM decoder: Standby=0, PowerOn=1, TP1..TP12=2..13, SRLSE=14, WAIT=15.
- `RUN`, `STEP`, `INST` and `STBY` each pass through a `SYNC_STAGES`-deep flop chain before use. The synchronized versions are called run_s, step_s, inst_s and stby_s below. `STRT` and `SNI` are used directly.
- Transitions, evaluated on every `CLK2` edge:
  - Standby: if `STRT` & !stby_s, go to PowerOn. Otherwise stay.
  - PowerOn: go to TP1 unconditionally. The CPM asserts R2000 here.
  - TP1..TP11: go to the next TP unconditionally.
  - TP12, first matching condition wins:
    - stby_s → Standby.
    - run_s → TP1.
    - inst_s & !`SNI` → TP1. This continues mid-instruction; the machine stops only at instruction boundaries.
    - otherwise → SRLSE.
  - SRLSE (wait for step release), first matching condition wins:
    - stby_s → Standby.
    - run_s → TP1.
    - !step_s → WAIT.
    - otherwise stay.
  - WAIT (wait for step press), first matching condition wins:
    - stby_s → Standby.
    - run_s | step_s → TP1.
    - otherwise stay.
- Standby is entered only from TP12, SRLSE or WAIT. A `STBY` assertion during TP1..TP11 never truncates a memory cycle.
- `MCT_CNT` increments by 1 on every edge where the state is TP12, whatever the next state is. It wraps from 255 to 0 and holds in all other states.
- Reset (`NPURST`=0), asynchronous and at any time including mid-cycle:
  - `TPG`=0 (Standby), `STOPPED`=1, `MCT_CNT`=0.
  - All synchronizer flops are cleared to 0.
  - After release, the machine stays in Standby until an `STRT` strobe arrives with stby_s=0.

## Timing
- `TPG` changes only on the `CLK2` rising edge, except for the asynchronous reset.
- A free-running memory cycle is exactly 12 clocks (TP1..TP12). There are no idle clocks between cycles when run_s=1.
- Power-on sequence: `STRT` sampled high in Standby → PowerOn on the next edge → TP1 on the edge after that.
- Panel latency: a change on `RUN`, `STEP`, `INST` or `STBY` affects transitions from the `SYNC_STAGES`-th edge after it is sampled (2 edges by default).
- From WAIT, step_s=1 gives TP1 on the next edge. Exactly one MCT (MCT step, `INST`=0) or one instruction (`INST`=1) runs per press, because re-arming requires passing through SRLSE with step_s=0.
- `STRT` pulses arriving outside Standby are ignored. `SNI` is ignored outside TP12.

## Test plan
- Reset and power-on:
  - Stimulus: hold `NPURST`=0, then release; `STBY`=0, `RUN`=1; pulse `STRT` for one clock.
  - Required: `TPG`=0 and `STOPPED`=1 during reset; then 0→1→2→…→13→2 repeating; `MCT_CNT`=3 after 36 clocks in TP states.
- MCT step:
  - Stimulus: `RUN`=0, `INST`=0, machine reaches TP12.
  - Required: `TPG`=14; stays at 14 while `STEP`=1; goes to 15 two clocks after `STEP`→0.
  - Stimulus: press `STEP` again.
  - Required: `TPG`=2 two clocks after the press, and exactly one cycle runs before the next stop.
- Instruction step:
  - Stimulus: `INST`=1, `RUN`=0; `SNI`=0 at the first TP12, `SNI`=1 at the second.
  - Required: no stop after the first TP12 (13→2); stop at SRLSE (14) after the second; `MCT_CNT` advances by 2.
- Standby entry and exit:
  - Stimulus: assert `STBY` during TP4 while running.
  - Required: the cycle completes through 13, then `TPG`=0.
  - Stimulus: `STRT` pulses while `STBY`=1.
  - Required: `TPG` stays 0.
  - Stimulus: deassert `STBY`, then pulse `STRT`.
  - Required: `TPG` goes 1 then 2.
- Wrap and mid-cycle reset:
  - Stimulus: run 256 MCTs.
  - Required: `MCT_CNT` returns to 0.
  - Stimulus: assert `NPURST`=0 during TP7.
  - Required: `TPG`=0 and `MCT_CNT`=0 immediately, without waiting for a clock edge.
